ks_poly_div: RTL and testbench

- Sequential GF(2)[x] polynomial long divider. It is the inverse companion to the combinational Karatsuba multipliers.
- Given a 2N-1-bit product and an N-bit divisor, it returns quotient and remainder. With d = a·b from the N-bit multiplier and divisor b, the quotient recovers a and the remainder is zero.
- Used for multiplier self-check and field-arithmetic support logic.
- One dividend bit position is retired per cycle, with a valid/ready handshake on both sides.

---
 rtl/ks_poly_div.sv | 153 +++++++++++++++
 tb/tb_ks_poly_div.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_poly_div.sv
// Sequential GF(2)[x] long divider: retires one dividend bit position per cycle.
// Define KS_POLY_DIV_EXACT_EN to register the zero-remainder "exact" flag; otherwise exact is tied low.
module ks_poly_div #(
   parameter int N = 117
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-2:0]   dividend,
   input  logic [N-1:0]     divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-2:0]   quotient,
   output logic [N-2:0]     remainder,
   output logic             div_zero,
   output logic             exact
);

   localparam int DW = 2*N-1;
   localparam int SW = $clog2(DW);
   localparam int TopInt = DW-1;
   localparam logic [SW-1:0] TopIdx = TopInt[SW-1:0];
   localparam logic [SW-1:0] ShOne  = {{(SW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] w_q, w_d;
   logic [DW-1:0] dAl_q, dAl_d;
   logic [DW-1:0] q_q, q_d;
   logic [SW-1:0] sh_q, sh_d;
   logic [SW-1:0] k_q, k_d;
   logic          divZero_q, divZero_d;
   logic [SW-1:0] posIdx;

   // Dividend bit sitting under the aligned divisor's leading term; modular wrap is harmless since k <= sh.
   assign posIdx = TopIdx - sh_q + k_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : NORM;
         NORM: if (dAl_q[DW-1]) state_d = DIV;
         DIV:  if (k_q == '0) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      w_d       = w_q;
      dAl_d     = dAl_q;
      q_d       = q_q;
      sh_d      = sh_q;
      k_d       = k_q;
      divZero_d = divZero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               w_d       = dividend;
               dAl_d     = {{(N-1){1'b0}}, divisor};
               q_d       = '0;
               sh_d      = '0;
               k_d       = '0;
               divZero_d = (divisor == '0);
            end
         end
         NORM: begin
            if (!dAl_q[DW-1]) begin
               dAl_d = dAl_q << 1;
               sh_d  = sh_q + ShOne;
            end else begin
               k_d = sh_q;
            end
         end
         DIV: begin
            if (w_q[posIdx]) begin
               w_d      = w_q ^ dAl_q;
               q_d[k_q] = 1'b1;
            end
            dAl_d = dAl_q >> 1;
            if (k_q != '0) k_d = k_q - ShOne;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q       <= '0;
         dAl_q     <= '0;
         q_q       <= '0;
         sh_q      <= '0;
         k_q       <= '0;
         divZero_q <= 1'b0;
      end else begin
         w_q       <= w_d;
         dAl_q     <= dAl_d;
         q_q       <= q_d;
         sh_q      <= sh_d;
         k_q       <= k_d;
         divZero_q <= divZero_d;
      end
   end

`ifdef KS_POLY_DIV_EXACT_EN
   logic exact_q, exact_d;

   // Sampled from the final working dividend on the edge that enters DONE.
   always_comb begin
      exact_d = exact_q;
      if (state_q == IDLE && in_valid) exact_d = 1'b0;
      else if (state_q == DIV && k_q == '0) exact_d = (w_d[N-2:0] == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exact_q <= 1'b0;
      end else begin
         exact_q <= exact_d;
      end
   end

   assign exact = exact_q && (state_q == DONE);
`else
   assign exact = 1'b0;
`endif

   // Results are only driven while presented, so a busy or aborted job never leaks partial values.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = 1'b0;
      quotient  = '0;
      remainder = '0;
      div_zero  = 1'b0;
      if (state_q == DONE) begin
         out_valid = 1'b1;
         quotient  = q_q;
         remainder = divZero_q ? '0 : w_q[N-2:0];
         div_zero  = divZero_q;
      end
   end

endmodule

// File: tb/tb_ks_poly_div.sv
// Scoreboard bench for ks_poly_div: expectations built from a carry-less product model at drive time.
module tb_ks_poly_div;

   localparam int N  = 117;
   localparam int DW = 2*N-1;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [N-1:0]  divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [N-2:0]  remainder;
   logic          div_zero;
   logic          exact;

   typedef struct {
      logic [DW-1:0] q;
      logic [N-2:0]  r;
      logic          dz;
      logic          ex;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   ks_poly_div #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_zero(div_zero), .exact(exact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rand233();
      logic [255:0] t;
      for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
      return t[DW-1:0];
   endfunction

   function automatic logic [N-1:0] rand117();
      logic [127:0] t;
      for (int i = 0; i < 4; i++) t[i*32 +: 32] = $urandom();
      return t[N-1:0];
   endfunction

   function automatic logic [DW-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < N; i++)
         if (b[i]) acc = acc ^ ({{(N-1){1'b0}}, a} << i);
      return acc;
   endfunction

   function automatic int degOf(input logic [N-1:0] b);
      int d;
      d = -1;
      for (int i = 0; i < N; i++) if (b[i]) d = i;
      return d;
   endfunction

   function automatic exp_t mkExp(input logic [DW-1:0] q, input logic [N-2:0] r, input logic dz);
      exp_t e;
      e.q  = q;
      e.r  = r;
      e.dz = dz;
`ifdef KS_POLY_DIV_EXACT_EN
      e.ex = (r == '0) && !dz;
`else
      e.ex = 1'b0;
`endif
      return e;
   endfunction

   // Pops one expectation per completed handshake and compares every result field.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL sb_unexpected: output with empty scoreboard, quotient=%h", quotient);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checks += 4;
            if (quotient !== e.q) begin
               errors++;
               $display("[TB] FAIL sb_quotient: got %h expected %h", quotient, e.q);
            end
            if (remainder !== e.r) begin
               errors++;
               $display("[TB] FAIL sb_remainder: got %h expected %h", remainder, e.r);
            end
            if (div_zero !== e.dz) begin
               errors++;
               $display("[TB] FAIL sb_div_zero: got %b expected %b", div_zero, e.dz);
            end
            if (exact !== e.ex) begin
               errors++;
               $display("[TB] FAIL sb_exact: got %b expected %b", exact, e.ex);
            end
         end
      end
   end

   // Drives one request, returns edges after the accepting edge until out_valid, then waits for retirement.
   task automatic applyStimulus(input logic [DW-1:0] d, input logic [N-1:0] b, output int lat);
      int guard;
      dividend = d;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 600) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("[TB] FAIL timeout: out_valid=%b after %0d edges, required 1", out_valid, lat);
      end
      guard = 0;
      while (out_valid && guard < 8) begin
         @(posedge clk); #1;
         guard++;
      end
   endtask

   task automatic test_reset();
      checks += 6;
      if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
      if (quotient !== '0)    begin errors++; $display("[TB] FAIL rst_quotient: got %h expected 0", quotient); end
      if (remainder !== '0)   begin errors++; $display("[TB] FAIL rst_remainder: got %h expected 0", remainder); end
      if (div_zero !== 1'b0)  begin errors++; $display("[TB] FAIL rst_div_zero: got %b expected 0", div_zero); end
      if (exact !== 1'b0)     begin errors++; $display("[TB] FAIL rst_exact: got %b expected 0", exact); end
   endtask

   task automatic test_basic();
      int lat;
      sb.push_back(mkExp(233'h3, 116'h0, 1'b0));
      applyStimulus(233'h5, 117'h3, lat);
      checks++;
      if (lat != 464) begin errors++; $display("[TB] FAIL basic_lat_5_3: got %0d expected 464", lat); end
      sb.push_back(mkExp(233'h2, 116'h1, 1'b0));
      applyStimulus(233'h7, 117'h3, lat);
      checks++;
      if (lat != 464) begin errors++; $display("[TB] FAIL basic_lat_7_3: got %0d expected 464", lat); end
   endtask

   task automatic test_boundary();
      int lat;
      logic [DW-1:0] d;
      logic [N-1:0]  b;
      d = rand233();
      sb.push_back(mkExp(d, '0, 1'b0));
      applyStimulus(d, 117'h1, lat);
      checks++;
      if (lat != 466) begin errors++; $display("[TB] FAIL lat_b1: got %0d expected 466", lat); end
      d = '0; d[DW-1] = 1'b1;
      b = '0; b[N-1]  = 1'b1;
      sb.push_back(mkExp({{(N-1){1'b0}}, b}, '0, 1'b0));
      applyStimulus(d, b, lat);
      checks++;
      if (lat != 234) begin errors++; $display("[TB] FAIL lat_bmax: got %0d expected 234", lat); end
   endtask

   task automatic test_zero_div();
      logic [DW-1:0] d;
      out_ready = 1'b0;
      d = rand233();
      sb.push_back(mkExp('0, '0, 1'b1));
      dividend = d;
      divisor  = '0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zdiv_latency: out_valid=%b expected 1 right after accept", out_valid); end
      dividend = rand233();
      divisor  = 117'h3;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks += 5;
         if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zdiv_hold_valid: got %b expected 1", out_valid); end
         if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL zdiv_hold_ready: got %b expected 0", in_ready); end
         if (quotient !== '0)    begin errors++; $display("[TB] FAIL zdiv_hold_q: got %h expected 0", quotient); end
         if (remainder !== '0)   begin errors++; $display("[TB] FAIL zdiv_hold_r: got %h expected 0", remainder); end
         if (div_zero !== 1'b1)  begin errors++; $display("[TB] FAIL zdiv_hold_dz: got %b expected 1", div_zero); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zdiv_release: out_valid=%b expected 0", out_valid); end
      if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL zdiv_no_capture: in_ready=%b expected 1", in_ready); end
   endtask

   task automatic test_roundtrip();
      int lat, dg, sh;
      logic [N-1:0]  a, b, m, r;
      logic [DW-1:0] d;
      for (int it = 0; it < 60; it++) begin
         a = rand117();
         if (a == '0) a = 117'h1;
         b = rand117() >> $urandom_range(0, N-1);
         if (b == '0) b = 117'h1;
         dg = degOf(b);
         m  = (117'(1) << dg) - 117'(1);
         r  = (it % 2 == 0) ? '0 : (rand117() & m);
         d  = clmul(a, b) ^ {{(N-1){1'b0}}, r};
         sh = (DW-1) - dg;
         sb.push_back(mkExp({{(N-1){1'b0}}, a}, r[N-2:0], 1'b0));
         applyStimulus(d, b, lat);
         checks++;
         if (lat != 2*sh+2) begin errors++; $display("[TB] FAIL rt_lat[%0d]: got %0d expected %0d", it, lat, 2*sh+2); end
      end
   endtask

   task automatic checkOutput();
      checks++;
      if (sb.size() != 0) begin errors++; $display("[TB] FAIL sb_leftover: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      int lat;
      dividend = 233'h5;
      divisor  = 117'h3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", out_valid); end
      if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL mid_rst_ready: got %b expected 1", in_ready); end
      if (quotient !== '0)    begin errors++; $display("[TB] FAIL mid_rst_q: got %h expected 0", quotient); end
      if (remainder !== '0)   begin errors++; $display("[TB] FAIL mid_rst_r: got %h expected 0", remainder); end
      if (div_zero !== 1'b0)  begin errors++; $display("[TB] FAIL mid_rst_dz: got %b expected 0", div_zero); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      sb.push_back(mkExp(233'h3, 116'h0, 1'b0));
      applyStimulus(233'h5, 117'h3, lat);
      checks++;
      if (lat != 464) begin errors++; $display("[TB] FAIL mid_rst_job_lat: got %0d expected 464", lat); end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_boundary();
      test_zero_div();
      test_roundtrip();
      test_reset_mid();
      repeat (2) @(posedge clk);
      checkOutput();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
